// File: rtl/cluster_pkg.sv
// Shared cluster word layout and scheduler types.
// A cluster is {cnt[2:0], adr[10:0]}; an all-ones address marks an empty slot.
package cluster_pkg;

    localparam int MXCLSTBITS = 14;
    localparam int MXCLUSTERS = 8;
    localparam int ADR_LSB    = 0;
    localparam int ADR_MSB    = 10;
    localparam logic [ADR_MSB-ADR_LSB:0] NULL_ADR = 11'h7FF;

    typedef logic [MXCLSTBITS-1:0] cluster_t;

    typedef struct packed {
        logic     sof;
        cluster_t data;
    } fifo_entry_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } tx_state_e;

endpackage

// File: rtl/cluster_fifo_mw.sv
// Circular buffer accepting up to NW consecutive entries per cycle and
// releasing one entry per cycle from the head.
module cluster_fifo_mw #(
    parameter int W     = 15,
    parameter int NW    = 8,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1,
    localparam int CW   = $clog2(NW + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [CW-1:0]         wr_n,
    input  logic [NW-1:0][W-1:0]  wr_data,
    input  logic                  rd_en,
    output logic [W-1:0]          rd_data,
    output logic                  empty,
    output logic [LW-1:0]         level
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;

    // Entry i of the write bundle lands i slots past the tail; the index wraps.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NW; i++) begin
                if (CW'(i) < wr_n) mem_q[wr_ptr_q + AW'(i)] <= wr_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(wr_n);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + (wr_en ? LW'(wr_n) : LW'(0)) - (rd_en ? LW'(1) : LW'(0));
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (level_q == '0);
    assign level   = level_q;

endmodule

// File: rtl/cluster_tx_scheduler.sv
// Compacts the valid clusters of each BX into a FIFO and streams them one
// per cycle over a valid/ready link, dropping whole BXs that do not fit.
module cluster_tx_scheduler #(
    parameter int          MXCLSTBITS = cluster_pkg::MXCLSTBITS,
    parameter int          MXCLUSTERS = cluster_pkg::MXCLUSTERS,
    parameter int          FIFO_DEPTH = 32,
    parameter logic [10:0] NULL_ADR   = cluster_pkg::NULL_ADR
) (
    input  logic                          clock4x,
    input  logic                          global_reset_n,
    input  logic                          enable,
    input  logic                          bx_strobe,
    input  logic [MXCLSTBITS-1:0]         cluster0,
    input  logic [MXCLSTBITS-1:0]         cluster1,
    input  logic [MXCLSTBITS-1:0]         cluster2,
    input  logic [MXCLSTBITS-1:0]         cluster3,
    input  logic [MXCLSTBITS-1:0]         cluster4,
    input  logic [MXCLSTBITS-1:0]         cluster5,
    input  logic [MXCLSTBITS-1:0]         cluster6,
    input  logic [MXCLSTBITS-1:0]         cluster7,
    input  logic                          link_ready,
    output logic                          link_valid,
    output logic [MXCLSTBITS-1:0]         link_data,
    output logic                          link_sof,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   overflow_cnt
);

    import cluster_pkg::*;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(MXCLUSTERS + 1);
    localparam int IW = $clog2(MXCLUSTERS);

    // Reset asserts asynchronously but releases two clock4x edges later.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) rst_sync_q <= '0;
        else                 rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [7:0][MXCLSTBITS-1:0]    clst_in;
    fifo_entry_t [MXCLUSTERS-1:0]  wr_data;
    logic [CW-1:0]                 n_vld;
    logic [IW-1:0]                 wr_idx;

    assign clst_in = {cluster7, cluster6, cluster5, cluster4,
                      cluster3, cluster2, cluster1, cluster0};

    always_comb begin
        wr_data = '0;
        n_vld   = '0;
        wr_idx  = '0;
        for (int i = 0; i < MXCLUSTERS; i++) begin
            if (clst_in[i][ADR_MSB:ADR_LSB] != NULL_ADR) begin
                wr_data[wr_idx].data = clst_in[i];
                wr_data[wr_idx].sof  = (n_vld == '0);
                wr_idx = wr_idx + IW'(1);
                n_vld  = n_vld + CW'(1);
            end
        end
    end

    logic [LW-1:0] lvl;
    logic [LW-1:0] free;
    logic          strobe_acc, bx_fits, wr_en, drop;
    logic          fifo_empty, out_load;
    fifo_entry_t   rd_entry;

    // Space is judged against the level before any same-cycle pop.
    assign free       = LW'(FIFO_DEPTH) - lvl;
    assign strobe_acc = bx_strobe && enable;
    assign bx_fits    = (LW'(n_vld) <= free);
    assign wr_en      = strobe_acc && (n_vld != '0) && bx_fits;
    assign drop       = strobe_acc && !bx_fits;

    cluster_fifo_mw #(
        .W     ($bits(fifo_entry_t)),
        .NW    (MXCLUSTERS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock4x),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_n    (n_vld),
        .wr_data (wr_data),
        .rd_en   (out_load),
        .rd_data (rd_entry),
        .empty   (fifo_empty),
        .level   (lvl)
    );

    tx_state_e                state_q;
    logic                     link_valid_q, link_sof_q;
    logic [MXCLSTBITS-1:0]    link_data_q;

    assign out_load = !fifo_empty && (!link_valid_q || link_ready);

    always_ff @(posedge clock4x or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            link_valid_q <= 1'b0;
            link_sof_q   <= 1'b0;
            link_data_q  <= MXCLSTBITS'(NULL_ADR);
        end else begin
            if (out_load) begin
                link_valid_q <= 1'b1;
                link_data_q  <= rd_entry.data;
                link_sof_q   <= rd_entry.sof;
            end else if (link_ready) begin
                link_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE:   if (wr_en) state_q <= ST_STREAM;
                ST_STREAM: if (link_valid_q && link_ready && fifo_empty && !wr_en)
                               state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    logic        overflow_q;
    logic [15:0] overflow_cnt_q, overflow_cnt_d;

    assign overflow_cnt_d = (drop && overflow_cnt_q != 16'hFFFF) ? overflow_cnt_q + 16'd1
                                                                  : overflow_cnt_q;

    always_ff @(posedge clock4x or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q     <= 1'b0;
            overflow_cnt_q <= '0;
        end else begin
            overflow_q     <= drop;
            overflow_cnt_q <= overflow_cnt_d;
        end
    end

    assign link_valid   = link_valid_q;
    assign link_data    = link_data_q;
    assign link_sof     = link_sof_q;
    assign fifo_level   = lvl;
    assign overflow     = overflow_q;
    assign overflow_cnt = overflow_cnt_q;

endmodule
